// File: rtl/parity_pkg.sv
// rtl/parity_pkg.sv - shared types and helpers for the streaming frame parity generator
package parity_pkg;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_e;

    // Width needed to hold counts 0..max_words inclusive.
    function automatic int cnt_width(input int max_words);
        return $clog2(max_words + 1);
    endfunction

endpackage

// File: rtl/xor_tree.sv
// rtl/xor_tree.sv - combinational XOR reduction, log2(WIDTH) levels halving per level
module xor_tree #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data_i,
    output logic             parity_o
);

    localparam int LEVELS = $clog2(WIDTH);

    genvar l, i;
    generate
        for (l = 0; l <= LEVELS; l++) begin : g_lvl
            logic [(WIDTH >> l)-1:0] v;
            if (l == 0) begin : g_leaf
                assign v = data_i;
            end else begin : g_node
                for (i = 0; i < (WIDTH >> l); i++) begin : g_x
                    assign v[i] = g_lvl[l-1].v[2*i] ^ g_lvl[l-1].v[2*i+1];
                end
            end
        end
    endgenerate

    assign parity_o = g_lvl[LEVELS].v[0];

endmodule

// File: rtl/parity_frame_gen.sv
// rtl/parity_frame_gen.sv - per-frame parity/count/overflow over a valid/ready word stream
// Optional receive-side check (in_chk/out_err) when PARITY_FRAME_CHECK_EN is defined.
module parity_frame_gen
    import parity_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_WORDS = 16,
    parameter int CNT_W     = cnt_width(MAX_WORDS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             odd_mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_parity,
    output logic [CNT_W-1:0] out_count,
    output logic             out_overflow
`ifdef PARITY_FRAME_CHECK_EN
    ,
    input  logic             in_chk,
    output logic             out_err
`endif
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    state_e             state_q, state_d;
    logic               acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mode_q, mode_d;
    logic               ovf_q, ovf_d;

    logic               oval_q, oval_d;
    logic               opar_q, opar_d;
    logic [CNT_W-1:0]   ocnt_q, ocnt_d;
    logic               oovf_q, oovf_d;

    logic               wp;
    logic               beat_acc;
    logic               done;
    logic               par_fin;
    logic [CNT_W-1:0]   cnt_fin;
    logic               ovf_fin;

    xor_tree #(.WIDTH(WIDTH)) u_xor_tree (
        .data_i   (in_data),
        .parity_o (wp)
    );

    // A pending result blocks input unless it is being drained this cycle.
    assign in_ready = ~oval_q | out_ready;
    assign beat_acc = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        ovf_d   = ovf_q;
        done    = 1'b0;
        par_fin = 1'b0;
        cnt_fin = cnt_q;
        ovf_fin = ovf_q;
        if (beat_acc) begin
            case (state_q)
                ST_IDLE: begin
                    mode_d  = odd_mode;
                    acc_d   = wp;
                    cnt_d   = ONE_CNT;
                    ovf_d   = 1'b0;
                    par_fin = wp ^ odd_mode;
                    cnt_fin = ONE_CNT;
                    ovf_fin = 1'b0;
                    if (in_last) begin
                        done = 1'b1;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    acc_d   = acc_q ^ wp;
                    cnt_d   = (cnt_q == MAX_CNT) ? cnt_q : cnt_q + ONE_CNT;
                    ovf_d   = ovf_q | (cnt_q == MAX_CNT);
                    par_fin = acc_d ^ mode_q;
                    cnt_fin = cnt_d;
                    ovf_fin = ovf_d;
                    if (in_last) begin
                        done    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // A completion in the same cycle as a drain overwrites the slot, keeping out_valid high.
    always_comb begin
        oval_d = oval_q;
        opar_d = opar_q;
        ocnt_d = ocnt_q;
        oovf_d = oovf_q;
        if (done) begin
            oval_d = 1'b1;
            opar_d = par_fin;
            ocnt_d = cnt_fin;
            oovf_d = ovf_fin;
        end else if (oval_q & out_ready) begin
            oval_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= 1'b0;
            cnt_q   <= '0;
            mode_q  <= PAR_EVEN;
            ovf_q   <= 1'b0;
            oval_q  <= 1'b0;
            opar_q  <= 1'b0;
            ocnt_q  <= '0;
            oovf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            ovf_q   <= ovf_d;
            oval_q  <= oval_d;
            opar_q  <= opar_d;
            ocnt_q  <= ocnt_d;
            oovf_q  <= oovf_d;
        end
    end

    assign out_valid    = oval_q;
    assign out_parity   = opar_q;
    assign out_count    = ocnt_q;
    assign out_overflow = oovf_q;

`ifdef PARITY_FRAME_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (done) begin
            err_d = par_fin ^ in_chk;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign out_err = err_q;
`endif

endmodule

// File: tb/tb_parity_frame_gen.sv
// tb/tb_parity_frame_gen.sv - directed and randomized checks against a frame-level reference model
module tb_parity_frame_gen;

    localparam int WIDTH = 8;
    localparam int MAXW  = 4;
    localparam int CW    = $clog2(MAXW + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             odd_mode = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_last = 1'b0;
    logic             out_ready = 1'b0;
    logic             in_ready;
    logic             out_valid;
    logic             out_parity;
    logic [CW-1:0]    out_count;
    logic             out_overflow;
`ifdef PARITY_FRAME_CHECK_EN
    logic             in_chk = 1'b0;
    logic             out_err;
`endif

    parity_frame_gen #(.WIDTH(WIDTH), .MAX_WORDS(MAXW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .odd_mode     (odd_mode),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_parity   (out_parity),
        .out_count    (out_count),
        .out_overflow (out_overflow)
`ifdef PARITY_FRAME_CHECK_EN
        ,
        .in_chk       (in_chk),
        .out_err      (out_err)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [WIDTH-1:0] frame_q[$];
    logic             frame_mode = 1'b0;
    logic             exp_valid = 1'b0;
    logic             exp_par = 1'b0;
    logic             exp_ovf = 1'b0;
    logic             exp_err = 1'b0;
    int               exp_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cycle(input logic v, input logic [WIDTH-1:0] d, input logic l,
                         input logic om, input logic ordy, input logic cb);
        logic exp_rdy, acc, cons;
        int   ones, sz;
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        odd_mode  = om;
        out_ready = ordy;
`ifdef PARITY_FRAME_CHECK_EN
        in_chk    = cb;
`endif
        @(negedge clk);
        exp_rdy = !exp_valid || ordy;
        chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
        acc  = v && exp_rdy;
        cons = exp_valid && ordy;
        @(posedge clk);
        #1;
        if (cons) exp_valid = 1'b0;
        if (acc) begin
            if (frame_q.size() == 0) frame_mode = om;
            frame_q.push_back(d);
            if (l) begin
                ones = 0;
                foreach (frame_q[i]) ones += $countones(frame_q[i]);
                sz        = frame_q.size();
                exp_par   = ones[0] ^ frame_mode;
                exp_cnt   = (sz > MAXW) ? MAXW : sz;
                exp_ovf   = (sz > MAXW);
                exp_err   = (exp_par != cb);
                exp_valid = 1'b1;
                frame_q.delete();
            end
        end
        chk("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
        if (exp_valid) begin
            chk("out_parity", {31'b0, out_parity}, {31'b0, exp_par});
            chk("out_count", 32'(out_count), 32'(exp_cnt));
            chk("out_overflow", {31'b0, out_overflow}, {31'b0, exp_ovf});
`ifdef PARITY_FRAME_CHECK_EN
            chk("out_err", {31'b0, out_err}, {31'b0, exp_err});
`endif
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        frame_q.delete();
        exp_valid = 1'b0;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_parity", {31'b0, out_parity}, 32'd0);
        chk("rst_out_count", 32'(out_count), 32'd0);
        chk("rst_out_overflow", {31'b0, out_overflow}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
`ifdef PARITY_FRAME_CHECK_EN
        chk("rst_out_err", {31'b0, out_err}, 32'd0);
`endif
    endtask

    initial begin
        do_reset();

        // single beat, even then odd parity
        cycle(1'b1, 8'h03, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("tp_even_par", {31'b0, out_parity}, 32'd0);
        chk("tp_even_cnt", 32'(out_count), 32'd1);
        cycle(1'b1, 8'h89, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("tp_odd_par", {31'b0, out_parity}, 32'd0);
        cycle(1'b1, 8'h89, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("tp_odd_even_par", {31'b0, out_parity}, 32'd1);

        // multi-beat with a gap; odd_mode toggling mid-frame must be ignored
        cycle(1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 8'h07, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("tp_multi_par", {31'b0, out_parity}, 32'd0);
        chk("tp_multi_cnt", 32'(out_count), 32'd3);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("tp_multi_once", {31'b0, out_valid}, 32'd0);

        // backpressure then drain with a back-to-back beat
        cycle(1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
            chk("tp_bp_hold_par", {31'b0, out_parity}, 32'd1);
        end
        chk("tp_bp_ready", {31'b0, in_ready}, 32'd0);
        cycle(1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("tp_bp_next_valid", {31'b0, out_valid}, 32'd1);
        chk("tp_bp_next_par", {31'b0, out_parity}, 32'd0);

        // overflow, then a clean frame
        for (int k = 0; k < 6; k++) cycle(1'b1, 8'h01, (k == 5), 1'b0, 1'b1, 1'b0);
        chk("tp_ovf_cnt", 32'(out_count), 32'd4);
        chk("tp_ovf_flag", {31'b0, out_overflow}, 32'd1);
        chk("tp_ovf_par", {31'b0, out_parity}, 32'd0);
        cycle(1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("tp_ovf_clear", {31'b0, out_overflow}, 32'd0);

        // reset mid-frame discards the partial frame
        cycle(1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
        do_reset();
        cycle(1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("tp_rst_par", {31'b0, out_parity}, 32'd1);
        chk("tp_rst_cnt", 32'(out_count), 32'd1);
`ifdef PARITY_FRAME_CHECK_EN
        chk("tp_rst_err", {31'b0, out_err}, 32'd1);
`endif

        for (int k = 0; k < 3000; k++) begin
            cycle($urandom_range(0, 3) != 0, WIDTH'($urandom), $urandom_range(0, 4) == 0,
                  1'($urandom), $urandom_range(0, 3) != 0, 1'($urandom));
        end
        for (int k = 0; k < 3; k++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/parity_frame_gen.md
Name: parity_frame_gen

Overview:
- Streaming successor to the combinational parity generator.
- Accepts WIDTH-bit words over a valid/ready handshake and accumulates parity across a multi-word frame delimited by in_last.
- Presents one registered result per frame: parity bit, beat count and overflow flag.
- Sits between a word source (bus/serializer) and a framer that appends the parity bit; supports even and odd parity.

Parameters:
- WIDTH, 8, data word width; power of 2, >= 2.
- MAX_WORDS, 16, beat-count saturation limit per frame; >= 1.
- CNT_W, $clog2(MAX_WORDS+1), derived width of out_count; not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- odd_mode  in  1  0 = even parity, 1 = odd parity; sampled on the first accepted beat of a frame.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  WIDTH  input word.
- in_last  in  1  final beat of the frame.
- out_valid  out  1  frame result valid.
- out_ready  in  1  downstream accepts the result.
- out_parity  out  1  frame parity bit.
- out_count  out  CNT_W  accepted beats in the frame, saturating at MAX_WORDS.
- out_overflow  out  1  frame contained more than MAX_WORDS beats.

Behaviour:
- Reset (rst_n=0 at posedge) clears all of the following, which are all 0 out of reset: state, acc, cnt, mode_q, out_valid, out_parity, out_count, out_overflow.
  - in_ready is 1 out of reset.
  - Reset mid-frame or with a result pending discards both.
- Handshakes:
  - Beat accepted when in_valid & in_ready.
  - Result consumed when out_valid & out_ready.
  - in_ready = ~out_valid | out_ready, combinational; no dependency on in_valid.
- Word parity: wp = XOR-reduce(in_data), combinational via the xor_tree sub-module, halving each level.
- FSM has two states:
  - IDLE:
    - On an accepted beat: mode_q <= odd_mode, acc <= wp, cnt <= 1.
    - If in_last is set, the frame completes in the same step (single-beat frame) and the state stays IDLE.
    - Otherwise go to ACCUM.
  - ACCUM:
    - On an accepted beat: acc <= acc ^ wp, cnt <= min(cnt+1, MAX_WORDS).
    - ovf <= ovf | (cnt == MAX_WORDS).
    - If in_last is set, complete the frame and go to IDLE.
- Frame completion:
  - Next cycle: out_valid=1, out_parity = acc_final ^ mode_q_final, out_count = cnt_final, out_overflow = ovf_final. The _final values include the last beat.
  - Latency: the result is valid exactly 1 cycle after the in_last beat is accepted.
- Output registers:
  - Hold stable while out_valid & ~out_ready.
  - A new completion while the old result is being consumed in the same cycle overwrites it; out_valid stays 1. This gives full throughput for back-to-back single-beat frames.
  - If the result is consumed with no completion that cycle, out_valid <= 0.
- Backpressure: while out_valid & ~out_ready, in_ready=0 and no beat is accepted, including mid-frame beats.
- Idle input: in_valid=0 leaves all state unchanged; frames may have gaps of any length.
- odd_mode changes mid-frame are ignored.

Optional Feature:
- Macro: PARITY_FRAME_CHECK_EN.
- Defined, the block gains extra ports:
  - in_chk  in  1  expected parity, sampled on the in_last beat.
  - out_err  out  1  registered alongside out_parity; = (computed parity != in_chk); reset 0.
- Defined, the block is also usable as a receive-side checker.
- Undefined, these ports do not exist and there is no extra logic.

Decomposition:
- Package parity_pkg holds:
  - PAR_EVEN=1'b0 and PAR_ODD=1'b1;
  - the FSM state encoding ST_IDLE / ST_ACCUM;
  - a clog2-based count-width function.
- Sub-module xor_tree #(WIDTH): generate-based log2(WIDTH)-level XOR reduction, purely combinational, one instance.

Test Plan:
- Single beat, even parity: even mode, 8'b00000011 with last, out_ready=1 -> next cycle out_valid=1, out_parity=0, out_count=1, out_overflow=0.
- Single beat, odd parity: odd mode, 8'b10001001 with last -> out_parity=0 (popcount 3). Same data in even mode -> out_parity=1.
- Multi-beat: 3-beat frame 0x01, 0x03, 0x07, even mode, with a 2-cycle in_valid gap after beat 1 -> out_parity=0, out_count=3, one result only.
- Backpressure: result pending with out_ready=0 for 5 cycles -> in_ready=0, outputs stable. Then out_ready=1 with the next single-beat frame 0xFF presented -> beat accepted the same cycle, next result out_parity=0, no bubble.
- Overflow: MAX_WORDS=4, 6-beat frame of 0x01, even mode -> out_count=4, out_overflow=1, out_parity=0. The following 1-beat frame reports out_overflow=0.
- Reset mid-frame: 2 beats of 0x01, rst_n=0 for 1 cycle, then a 1-beat frame 0x01 -> out_parity=1, out_count=1. If the checker is enabled, in_chk=0 on that frame gives out_err=1.
